// File: rtl/flow_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flow_pkg
//  Purpose  : Shared constants and types for the 8-to-16 byte packer:
//             byte-enable codes, packer state encoding, FIFO entry layout.
//  Revision : 1.0 - initial release
// ============================================================================
package flow_pkg;

  // Byte-enable codes carried with each packed word
  localparam logic [1:0] BE_FULL = 2'b11;
  localparam logic [1:0] BE_HALF = 2'b01;

  // Packer state: LO = no byte held, HI = low byte held in lo_hold
  typedef enum logic [0:0] {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } pack_state_e;

  // FIFO entry layout: 16 data + 2 byte enables + 1 last
  localparam int ENTRY_DATA_W = 16;
  localparam int ENTRY_BE_W   = 2;
  localparam int ENTRY_LAST_W = 1;
  localparam int ENTRY_W      = ENTRY_DATA_W + ENTRY_BE_W + ENTRY_LAST_W;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic [ENTRY_BE_W-1:0]   be;
    logic                    last;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/flow_8to16_if.sv
`default_nettype none
// ============================================================================
//  Module   : flow_8to16_if
//  Purpose  : Byte-in / word-out valid-ready bundle for the 8-to-16 packer.
//             master = traffic environment (drives bytes, accepts words),
//             slave  = packer (accepts bytes, drives words).
//  Revision : 1.0 - initial release
// ============================================================================
interface flow_8to16_if;
  logic        src_val;
  logic        src_rdy;
  logic [7:0]  src_data;
  logic        src_last;
  logic        dst_val;
  logic        dst_rdy;
  logic [15:0] dst_data;
  logic [1:0]  dst_be;
  logic        dst_last;

  modport master (
    output src_val, src_data, src_last, dst_rdy,
    input  src_rdy, dst_val, dst_data, dst_be, dst_last
  );

  modport slave (
    input  src_val, src_data, src_last, dst_rdy,
    output src_rdy, dst_val, dst_data, dst_be, dst_last
  );
endinterface
`default_nettype wire

// File: rtl/flow_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : flow_fifo
//  Purpose  : Generic synchronous valid-ready FIFO with synchronous flush.
//             Pointers carry one extra wrap bit; head is zero when empty.
//  Revision : 1.0 - initial release
// ============================================================================
module flow_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             full_w;
  logic             empty_w;
  logic             push_w;
  logic             pop_w;

  // Status decoded from registered pointers only
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_w = (wr_ptr_q == rd_ptr_q);

  assign in_rdy   = ~full_w;
  assign out_val  = ~empty_w;
  assign push_w   = in_val & ~full_w;
  assign pop_w    = ~empty_w & out_rdy;
  assign out_data = empty_w ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for storage and pointers; flush empties by resetting pointers
  always_comb begin
    mem_d = mem_q;
    if (push_w) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_data;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_w};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_w};
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/flow_8to16.sv
`default_nettype none
// ============================================================================
//  Module   : flow_8to16
//  Purpose  : Byte-to-word packer. Low byte first; an odd trailing byte of a
//             packet is emitted as a half word padded with PAD_BYTE. Words
//             pass through an output FIFO (never bypassed).
//  Revision : 1.0 - initial release
// ============================================================================
module flow_8to16
  import flow_pkg::*;
#(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_en,
  flow_8to16_if.slave   bus,
  output logic [15:0]   stat_words
);

  pack_state_e state_q, state_d;
  logic [7:0]  lo_hold_q, lo_hold_d;
  logic [15:0] stat_words_q, stat_words_d;
  logic        run_q, run_d;

  logic        fifo_in_rdy;
  logic        fifo_out_val;
  logic [ENTRY_W-1:0] fifo_out_data;
  logic        push_val;
  fifo_entry_t push_entry;
  fifo_entry_t head_entry;

  logic        src_rdy_w;
  logic        byte_acc_w;
  logic        word_acc_w;

  // run_q holds src_rdy low until the first edge out of reset
  assign src_rdy_w  = cfg_en & run_q & fifo_in_rdy;
  assign byte_acc_w = bus.src_val & src_rdy_w;
  assign word_acc_w = fifo_out_val & bus.dst_rdy;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a non-last byte in LO moves to HI, any byte in HI completes the word
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LO: if (byte_acc_w && !bus.src_last) state_d = ST_HI;
      ST_HI: if (byte_acc_w)                  state_d = ST_LO;
      default:                                state_d = ST_LO;
    endcase
    if (!cfg_en) begin
      state_d = ST_LO;
    end
  end

  // Output decode: build the FIFO entry for the word completed this cycle
  always_comb begin
    push_val   = 1'b0;
    push_entry = '0;
    case (state_q)
      ST_LO: begin
        if (byte_acc_w && bus.src_last) begin
          push_val   = 1'b1;
          push_entry = '{data: {PAD_BYTE, bus.src_data}, be: BE_HALF, last: 1'b1};
        end
      end
      ST_HI: begin
        if (byte_acc_w) begin
          push_val   = 1'b1;
          push_entry = '{data: {bus.src_data, lo_hold_q}, be: BE_FULL, last: bus.src_last};
        end
      end
      default: begin
        push_val = 1'b0;
      end
    endcase
  end

  // Datapath next-state: low-byte capture, word counter, ready gate
  always_comb begin
    lo_hold_d = lo_hold_q;
    if (!cfg_en) begin
      lo_hold_d = 8'h00;
    end else if (state_q == ST_LO && byte_acc_w && !bus.src_last) begin
      lo_hold_d = bus.src_data;
    end
    stat_words_d = stat_words_q + {15'd0, word_acc_w};
    run_d        = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_hold_q    <= 8'h00;
      stat_words_q <= 16'h0000;
      run_q        <= 1'b0;
    end else begin
      lo_hold_q    <= lo_hold_d;
      stat_words_q <= stat_words_d;
      run_q        <= run_d;
    end
  end

  flow_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (~cfg_en),
    .in_val   (push_val),
    .in_rdy   (fifo_in_rdy),
    .in_data  (push_entry),
    .out_val  (fifo_out_val),
    .out_rdy  (bus.dst_rdy),
    .out_data (fifo_out_data)
  );

  assign head_entry   = fifo_entry_t'(fifo_out_data);
  assign bus.src_rdy  = src_rdy_w;
  assign bus.dst_val  = fifo_out_val;
  assign bus.dst_data = head_entry.data;
  assign bus.dst_be   = head_entry.be;
  assign bus.dst_last = head_entry.last;
  assign stat_words   = stat_words_q;

endmodule
`default_nettype wire

// File: tb/tb_flow_8to16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flow_8to16
//  Purpose  : Self-checking bench for flow_8to16 with a queue-based
//             reference model of byte pairing and packet flushing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flow_8to16;

  localparam int         DEPTH    = 2;
  localparam logic [7:0] PAD_BYTE = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [15:0] stat_words;
  logic        dir_rdy;
  logic        rnd_rdy;
  logic        rnd_mode;
  logic        mon_en;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  // Reference model state
  logic [18:0] exp_q[$];
  logic        have_lo;
  logic [7:0]  lo_byte;
  logic [15:0] exp_stat;

  flow_8to16_if bus ();

  flow_8to16 #(
    .DEPTH    (DEPTH),
    .PAD_BYTE (PAD_BYTE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .bus        (bus.slave),
    .stat_words (stat_words)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign bus.dst_rdy = rnd_mode ? rnd_rdy : dir_rdy;

  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    have_lo  = 1'b0;
    lo_byte  = 8'h00;
    exp_stat = 16'h0000;
  endfunction

  // Bytes pair low-first; a packet end with an unpaired byte yields a padded half word
  function automatic void model_byte(input logic [7:0] d, input logic last);
    if (have_lo) begin
      exp_q.push_back({d, lo_byte, 2'b11, last});
      have_lo = 1'b0;
    end else if (last) begin
      exp_q.push_back({PAD_BYTE, d, 2'b01, 1'b1});
    end else begin
      lo_byte = d;
      have_lo = 1'b1;
    end
  endfunction

  // Cycle monitor: sampled on the falling edge, handshakes resolve on the next rising edge
  always @(negedge clk) begin
    if (mon_en) begin
      check("src_rdy", {31'd0, bus.src_rdy}, {31'd0, cfg_en && (exp_q.size() < DEPTH)});
      check("dst_val", {31'd0, bus.dst_val}, {31'd0, exp_q.size() != 0});
      check("stat_words", {16'd0, stat_words}, {16'd0, exp_stat});
      if (exp_q.size() == 0) begin
        check("empty_head", {13'd0, bus.dst_data, bus.dst_be, bus.dst_last}, 32'd0);
      end
      if (bus.dst_val && bus.dst_rdy) begin
        if (exp_q.size() != 0) begin
          check("word", {13'd0, bus.dst_data, bus.dst_be, bus.dst_last}, {13'd0, exp_q.pop_front()});
        end
        exp_stat = exp_stat + 16'd1;
      end
      if (bus.src_val && bus.src_rdy) begin
        model_byte(bus.src_data, bus.src_last);
      end
      if (!cfg_en) begin
        exp_q.delete();
        have_lo = 1'b0;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    bus.src_val  = 1'b1;
    bus.src_data = d;
    bus.src_last = last;
    @(negedge clk);
    while (!bus.src_rdy && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.src_val  = 1'b0;
    bus.src_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bus.dst_val && n < 300) begin
      n++;
      @(posedge clk);
      #1;
    end
    if (n >= 300) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] s0;
    logic [15:0] first_word;
    int          t0;

    rst_n        = 1'b0;
    cfg_en       = 1'b1;
    bus.src_val  = 1'b0;
    bus.src_data = 8'h00;
    bus.src_last = 1'b0;
    dir_rdy      = 1'b1;
    rnd_mode     = 1'b0;
    mon_en       = 1'b0;
    model_reset();

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_src_rdy", {31'd0, bus.src_rdy}, 32'd0);
    check("rst_dst_val", {31'd0, bus.dst_val}, 32'd0);
    check("rst_dst_data", {16'd0, bus.dst_data}, 32'd0);
    check("rst_dst_be", {30'd0, bus.dst_be}, 32'd0);
    check("rst_dst_last", {31'd0, bus.dst_last}, 32'd0);
    check("rst_stat", {16'd0, stat_words}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_src_rdy", {31'd0, bus.src_rdy}, 32'd1);
    check("first_dst_val", {31'd0, bus.dst_val}, 32'd0);
    mon_en = 1'b1;

    // Basic pack
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    check("basic_val", {31'd0, bus.dst_val}, 32'd1);
    check("basic_data", {16'd0, bus.dst_data}, 32'h1234);
    check("basic_be", {30'd0, bus.dst_be}, 32'h3);
    check("basic_last", {31'd0, bus.dst_last}, 32'd0);
    idle(1);
    check("basic_stat", {16'd0, stat_words}, 32'd1);

    // Odd packet: full word then padded half word
    dir_rdy = 1'b0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    check("odd_w0", {13'd0, bus.dst_data, bus.dst_be, bus.dst_last}, {13'd0, 16'hBBAA, 2'b11, 1'b0});
    dir_rdy = 1'b1;
    idle(1);
    check("odd_w1", {13'd0, bus.dst_data, bus.dst_be, bus.dst_last}, {13'd0, 16'h00CC, 2'b01, 1'b1});
    drain();

    // Back-pressure: four bytes fill both slots, then the head must hold
    dir_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b0);
    first_word = 16'h4140;
    @(negedge clk);
    check("bp_src_rdy", {31'd0, bus.src_rdy}, 32'd0);
    check("bp_head", {16'd0, bus.dst_data}, {16'd0, first_word});
    idle(3);
    check("bp_hold", {16'd0, bus.dst_data}, {16'd0, first_word});
    dir_rdy = 1'b1;
    for (int i = 4; i < 8; i++) send_byte(8'h40 + 8'(i), 1'b0);
    drain();
    idle(1);
    check("bp_count", {16'd0, stat_words}, 32'd7);

    // Throughput: eight bytes in eight cycles with both sides ready
    t0 = cyc;
    for (int i = 0; i < 8; i++) send_byte(8'(i * 17), 1'b0);
    check("throughput", cyc - t0, 32'd8);
    drain();

    // Randomized traffic with random downstream ready
    rnd_mode = 1'b1;
    for (int i = 0; i < 2 * (2 * DEPTH + 3) * 4; i++) begin
      send_byte(8'($urandom), $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) idle(1);
    end
    send_byte(8'h99, 1'b1);
    drain();
    rnd_mode = 1'b0;
    dir_rdy  = 1'b1;
    drain();

    // Counter wrap: preload near the top, then two words
    dir_rdy = 1'b0;
    idle(1);
    force dut.stat_words_q = 16'hFFFE;
    exp_stat = 16'hFFFE;
    #1 release dut.stat_words_q;
    idle(1);
    check("wrap_pre", {16'd0, stat_words}, 32'h0000FFFE);
    dir_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i), 1'b0);
    drain();
    idle(1);
    check("wrap_post", {16'd0, stat_words}, 32'd0);

    // Disable mid-word with one word queued
    dir_rdy = 1'b0;
    send_byte(8'h10, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h55, 1'b0);
    s0 = stat_words;
    cfg_en = 1'b0;
    idle(1);
    cfg_en = 1'b1;
    check("dis_dst_val", {31'd0, bus.dst_val}, 32'd0);
    check("dis_stat", {16'd0, stat_words}, {16'd0, s0});
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    check("dis_word", {16'd0, bus.dst_data}, 32'h0201);
    dir_rdy = 1'b1;
    drain();

    // Asynchronous reset mid-operation
    dir_rdy = 1'b0;
    send_byte(8'h77, 1'b1);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_dst_val", {31'd0, bus.dst_val}, 32'd0);
    check("arst_src_rdy", {31'd0, bus.src_rdy}, 32'd0);
    check("arst_dst_data", {16'd0, bus.dst_data}, 32'd0);
    check("arst_stat", {16'd0, stat_words}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    dir_rdy = 1'b1;
    send_byte(8'h21, 1'b0);
    send_byte(8'h43, 1'b1);
    drain();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/flow_8to16.md
Name: flow_8to16

Overview:
Byte-to-word packer that sits directly downstream of the 16-to-8 converter and rebuilds a 16-bit valid-ready flow from the 8-bit stream. Bytes arrive low byte first: byte 0 becomes bits [7:0] and byte 1 becomes bits [15:8]. An optional src_last marks a packet end, so an odd trailing byte is flushed as a half word with byte enables. A small output FIFO decouples the two sides, giving one byte per cycle on input and preventing back-pressure bubbles.

Parameters:
DEPTH, 2, output FIFO depth in words; power of 2, minimum 2
PAD_BYTE, 8'h00, value driven on dst_data[15:8] for a half word

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous reset, active low
cfg_en  input  1  enable, active high; protocol may be violated on disable
src_val  input  1  byte valid, active high
src_rdy  output  1  byte ready, active high
src_data  input  8  byte data, steady on valid
src_last  input  1  last byte of packet, qualified by src_val
dst_val  output  1  word valid, active high
dst_rdy  input  1  word ready, active high
dst_data  output  16  word data, steady on valid
dst_be  output  2  byte enables: 2'b11 full word, 2'b01 half word
dst_last  output  1  word ends a packet
stat_words  output  16  count of words accepted downstream; wraps at 16'hFFFF

Behaviour:
- Reset values: src_rdy=0, dst_val=0, dst_data=0, dst_be=0, dst_last=0, stat_words=0, FIFO empty, state LO.
- src_rdy = cfg_en & ~fifo_full.
  - fifo_full is decoded from registered pointers only.
  - There is no combinational path from any input except cfg_en.
- Byte accept: src_val & src_rdy.
- Word accept: dst_val & dst_rdy.
- State LO, no byte held:
  - Byte accepted with src_last=0: byte goes to the lo_hold register, next state HI.
  - Byte accepted with src_last=1: push {PAD_BYTE, byte}, be=01, last=1; stay in LO.
- State HI, low byte held:
  - Byte accepted: push {byte, lo_hold}, be=11, last=src_last; next state LO.
- Latency: a pushed word is visible on dst_val in the cycle after the accepting edge.
- The FIFO is not bypassed.
- Throughput: one byte per cycle sustained while dst_rdy=1.
- dst_data, dst_be and dst_last are driven from the FIFO head.
  - They are steady while dst_val & ~dst_rdy.
  - They are zero when the FIFO is empty.
- Simultaneous push and pop:
  - Allowed whenever not full; occupancy is unchanged.
  - When full, src_rdy=0, so only a pop occurs. The freed slot raises src_rdy on the next cycle.
- Pointers: log2(DEPTH)+1 bits.
  - Wrap-around is handled by the MSB compare.
  - full = MSBs differ and the rest of the pointer is equal.
  - empty = pointers equal.
- stat_words increments on each word accept and wraps to 0 after 16'hFFFF.
- cfg_en=0 acts as a synchronous flush:
  - FIFO emptied and state forced to LO; lo_hold is discarded.
  - dst_val, src_rdy, dst_data, dst_be and dst_last go to 0 on the next edge.
  - stat_words holds its value.
- rst_n asserted mid-operation returns every output to its reset value immediately, without waiting for a clock edge.
- A held low byte with no following byte waits indefinitely; there is no timeout.

Decomposition:
- Shared package (flow_pkg):
  - Byte-enable constants BE_FULL=2'b11 and BE_HALF=2'b01.
  - Packer state encoding ST_LO / ST_HI.
  - FIFO entry field widths: 16 data + 2 be + 1 last = 19 bits.
- One sub-module: flow_fifo.
  - Generic synchronous valid-ready FIFO with parameters WIDTH and DEPTH, plus a flush input.
  - Instantiated with WIDTH=19.
- The packer FSM, lo_hold register and stat_words counter stay in the top level.

Test Plan:
- Reset and idle: hold rst_n=0, then release with cfg_en=1 -> all outputs 0 during reset; src_rdy=1 on the first edge after release; dst_val=0.
- Basic pack: bytes 8'h34 then 8'h12, src_last=0, dst_rdy=1 -> one word dst_data=16'h1234, be=11, last=0, dst_val the cycle after the second byte; stat_words=1.
- Odd packet: bytes 8'hAA, 8'hBB, 8'hCC with last on CC, PAD_BYTE=8'h00 -> words 16'hBBAA (be=11, last=0) then 16'h00CC (be=01, last=1).
- Back-pressure: dst_rdy=0 while 8 bytes are streamed, DEPTH=2 ->
  - src_rdy falls after 4 bytes (2 words).
  - dst_data holds 16'h first word while stalled.
  - After dst_rdy=1 all 4 words arrive in order with no loss or duplication.
- Wrap-around: stream 2*DEPTH+3 words with random dst_rdy -> scoreboard matches, no gap when both sides are continuously ready; stat_words is set to 16'hFFFE by test force, then reaches 16'h0000 after 2 more words.
- Disable mid-word: accept 8'h55 (state HI), then cfg_en=0 for 1 cycle with 1 word queued ->
  - FIFO empties and dst_val=0.
  - After re-enable, bytes 8'h01, 8'h02 yield 16'h0201, not 16'h??55.
  - stat_words is unchanged across the disable.
